ps2_scancode_rx: RTL and testbench
==================================

// Module: ps2_scancode_rx
// PURPOSE
//   PS/2 keyboard receiver, directly upstream of the ball-control stage.
//   - Synchronises and glitch-filters PS2_CLK/PS2_DATA.
//   - Deserialises 11-bit device-to-host frames, checks parity and stop bit.
//   - Folds E0 (extended) and F0 (break) prefixes into flags on the next data byte.
//   - Emits one code_valid pulse per complete make/break code for the consumer.
// PARAMETERS
//   FILTER_LEN      4      consecutive equal samples before filtered PS2_CLK changes
//   TIMEOUT_CYCLES  10000  CLK cycles with no falling edge mid-frame before abort (200 us at 50 MHz)
// PORTS
//   CLK          in   1  system clock, single clock domain
//   reset_n      in   1  asynchronous active-low reset
//   PS2_CLK      in   1  raw keyboard clock, asynchronous to CLK
//   PS2_DATA     in   1  raw keyboard data, asynchronous to CLK
//   scan_code    out  8  last decoded code byte, prefixes stripped
//   is_break     out  1  scan_code was preceded by F0 (key release)
//   is_extended  out  1  scan_code was preceded by E0
//   code_valid   out  1  one-cycle strobe: scan_code/flags updated this cycle
//   frame_err    out  1  one-cycle strobe: parity, stop or timeout error
// BEHAVIOUR
//   Reset: all outputs 0, FSM IDLE, pending flags 0, shift register 0, filter output 1.
//   Input conditioning
//   - Two-flop synchroniser on each raw line.
//   - Filtered clock changes only after FILTER_LEN equal synchronised samples.
//   - fall = filtered clock 1->0, registered: a single-cycle event.
//   - PS2_DATA is sampled from its synchroniser in the cycle fall is high.
//   FSM (advances only on fall, except timeout)
//   - IDLE: data==0 (start) -> DATA with bit_cnt=0; data==1 -> ignored, stay IDLE.
//   - DATA: shift data in LSB-first; after the 8th bit (bit_cnt==7) -> PARITY.
//   - PARITY: capture parity bit -> STOP.
//   - STOP: frame accepted if ^{byte,parity}==1 (odd parity) and data==1; then -> IDLE.
//   Accepted byte handling (same cycle as stop-bit fall; outputs registered)
//   - 8'hE0: ext_pend<=1; no code_valid.
//   - 8'hF0: brk_pend<=1; no code_valid.
//   - Any other byte:
//       scan_code<=byte, is_break<=brk_pend, is_extended<=ext_pend,
//       code_valid<=1 for exactly one cycle, then both pend flags <=0.
//   - Latency: code_valid is high in the cycle after the stop-bit fall event.
//   - scan_code and flags hold their values until the next code_valid.
//   Errors
//   - Parity or stop failure:
//       frame_err pulses 1 cycle, byte discarded, pend flags cleared, -> IDLE.
//   - Timeout:
//       counter clears on every fall and counts while not IDLE.
//       Reaching TIMEOUT_CYCLES -> frame_err pulse, pend flags cleared, -> IDLE.
//   - fall and timeout in the same cycle: fall wins, counter clears.
//   - Timeout counter width = $clog2(TIMEOUT_CYCLES+1); it saturates, no wrap.
//   - code_valid and frame_err are never high together.
//   - Async reset mid-frame: partial frame and pend flags are lost.
//       Decoding resumes at the next start bit after reset release.
// STRUCTURE
//   - Package ps2_pkg:
//       PS2_EXT_PREFIX=8'hE0, PS2_BRK_PREFIX=8'hF0
//       rx state enum {IDLE,DATA,PARITY,STOP}
//   - Sub-module ps2_line_filter:
//       synchroniser + FILTER_LEN filter + falling-edge detect
//       outputs clk_fall, data_sync
//   - Top: FSM, shift register, bit counter, timeout counter, prefix tracking.
// TESTING
//   1. Frame 0x1D, parity 1, stop 1
//        -> code_valid pulse, scan_code=8'h1D, is_break=0, is_extended=0.
//   2. Frames F0 then 1D
//        -> exactly one code_valid, scan_code=8'h1D, is_break=1, is_extended=0.
//   3. Frames E0, F0, 75
//        -> exactly one code_valid, scan_code=8'h75, is_break=1, is_extended=1;
//           a following plain 75 reports both flags 0.
//   4. Frame 0x1D with parity 0
//        -> frame_err pulse, no code_valid, scan_code keeps its previous value.
//   5. Start bit + 3 data bits, then PS2_CLK held high 10001 cycles
//        -> frame_err pulse, FSM IDLE;
//           next full frame 0x29 decodes to scan_code=8'h29.
//   6. 2-cycle low glitch on PS2_CLK while IDLE -> no state change;
//      reset_n low mid-frame -> all outputs 0 immediately, next frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
//   Shared definitions for the PS/2 scan-code receiver.
//   - Prefix bytes that are folded into flags rather than reported as codes.
//   - Receive FSM state encoding.
//   - Odd-parity helper for an 8-bit byte plus its parity bit.
// ----------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // A PS/2 frame carries odd parity: data bits plus parity bit have an odd
    // number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ----------------------------------------------------------------------------
// ps2_line_filter
//   Conditions the raw PS/2 lines for the receiver FSM.
//   - Two-flop synchroniser on PS2_CLK and PS2_DATA.
//   - The filtered clock only changes after FILTER_LEN consecutive
//     synchronised samples disagree with it, so short glitches are ignored.
//   - o_clk_fall is a registered single-cycle pulse on filtered 1->0.
// Ports
//   CLK          in   system clock
//   reset_n      in   asynchronous active-low reset
//   i_ps2_clk    in   raw keyboard clock
//   i_ps2_data   in   raw keyboard data
//   o_clk_fall   out  one-cycle pulse on filtered clock falling edge
//   o_data_sync  out  synchronised keyboard data
// ----------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_clk_fall,
    output logic o_data_sync
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          r_clk_s1;
    logic          r_clk_s2;
    logic          r_data_s1;
    logic          r_data_s2;
    logic          r_filt;
    logic [CW-1:0] r_cnt;
    logic          r_fall;

    // Idle PS/2 lines are high, so the synchronisers and the filter come out
    // of reset at 1 and reset itself never looks like a falling edge.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
        end else begin
            r_clk_s1  <= i_ps2_clk;
            r_clk_s2  <= r_clk_s1;
            r_data_s1 <= i_ps2_data;
            r_data_s2 <= r_data_s1;
        end
    end

    // r_cnt counts consecutive samples that differ from the filtered value;
    // any agreeing sample restarts the run.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_filt <= 1'b1;
            r_cnt  <= '0;
            r_fall <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clk_s2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_filt <= r_clk_s2;
                r_cnt  <= '0;
                r_fall <= ~r_clk_s2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_clk_fall  = r_fall;
    assign o_data_sync = r_data_s2;

endmodule

// File: rtl/ps2_scancode_rx.sv
// ----------------------------------------------------------------------------
// ps2_scancode_rx
//   PS/2 keyboard receiver. Deserialises 11-bit device-to-host frames,
//   checks odd parity and the stop bit, folds E0/F0 prefixes into flags on
//   the following code byte and emits one code_valid strobe per make/break
//   code.
// Ports
//   CLK          in   system clock
//   reset_n      in   asynchronous active-low reset
//   PS2_CLK      in   raw keyboard clock (asynchronous)
//   PS2_DATA     in   raw keyboard data (asynchronous)
//   scan_code    out  last decoded code byte, prefixes stripped
//   is_break     out  scan_code was preceded by F0
//   is_extended  out  scan_code was preceded by E0
//   code_valid   out  one-cycle strobe, scan_code/flags updated
//   frame_err    out  one-cycle strobe, parity/stop/timeout error
// ----------------------------------------------------------------------------
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] scan_code,
    output logic       is_break,
    output logic       is_extended,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic            w_fall;
    logic            w_data;
    rx_state_t       r_state;
    rx_state_t       w_state_nxt;
    logic            w_frame_ok;
    logic            w_frame_bad;
    logic            w_timeout;

    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic            r_parity;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_ext_pend;
    logic            r_brk_pend;

    logic [7:0]      r_scan_code;
    logic            r_is_break;
    logic            r_is_extended;
    logic            r_code_valid;
    logic            r_frame_err;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .i_ps2_clk   (PS2_CLK),
        .i_ps2_data  (PS2_DATA),
        .o_clk_fall  (w_fall),
        .o_data_sync (w_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the values from before the clock edge, independent of block order.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_frame_ok  = 1'b0;
        w_frame_bad = 1'b0;
        w_timeout   = 1'b0;
        if (w_fall) begin
            unique case (r_state)
                IDLE:   if (!w_data) w_state_nxt = DATA;
                DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
                PARITY: w_state_nxt = STOP;
                STOP: begin
                    w_state_nxt = IDLE;
                    if (odd_parity_ok(r_shift, r_parity) && w_data) begin
                        w_frame_ok = 1'b1;
                    end else begin
                        w_frame_bad = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end else if (r_state != IDLE && r_to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
            // A fall in the same cycle takes the branch above, so fall wins.
            w_timeout   = 1'b1;
            w_state_nxt = IDLE;
        end
    end

    // Frame deserialiser: bits arrive LSB first, so shift in from the top.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
        end else if (w_fall) begin
            unique case (r_state)
                IDLE:   r_bit_cnt <= '0;
                DATA: begin
                    r_shift   <= {w_data, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                PARITY: r_parity <= w_data;
                default: ;
            endcase
        end
    end

    // Inter-edge watchdog: cleared by each fall, idle while waiting for a
    // start bit, saturating at the limit rather than wrapping.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (w_fall || r_state == IDLE) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Prefix folding and registered outputs. Prefix bytes only arm a pending
    // flag; the next real code consumes both flags.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_ext_pend    <= 1'b0;
            r_brk_pend    <= 1'b0;
            r_scan_code   <= '0;
            r_is_break    <= 1'b0;
            r_is_extended <= 1'b0;
            r_code_valid  <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_frame_ok) begin
                if (r_shift == PS2_EXT_PREFIX) begin
                    r_ext_pend <= 1'b1;
                end else if (r_shift == PS2_BRK_PREFIX) begin
                    r_brk_pend <= 1'b1;
                end else begin
                    r_scan_code   <= r_shift;
                    r_is_break    <= r_brk_pend;
                    r_is_extended <= r_ext_pend;
                    r_code_valid  <= 1'b1;
                    r_ext_pend    <= 1'b0;
                    r_brk_pend    <= 1'b0;
                end
            end else if (w_frame_bad || w_timeout) begin
                r_frame_err <= 1'b1;
                r_ext_pend  <= 1'b0;
                r_brk_pend  <= 1'b0;
            end
        end
    end

    assign scan_code   = r_scan_code;
    assign is_break    = r_is_break;
    assign is_extended = r_is_extended;
    assign code_valid  = r_code_valid;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_scancode_rx
//   Drives PS/2 frames into ps2_scancode_rx. A frame-level model turns each
//   sent frame into an expected event (code with flags, or error); a monitor
//   matches every code_valid/frame_err strobe against that queue and checks
//   that outputs hold between strobes.
// ----------------------------------------------------------------------------
module tb_ps2_scancode_rx;
    import ps2_pkg::*;

    localparam int HALF = 20;   // CLK cycles per PS/2 clock half-period

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         brk;
        bit         ext;
    } ev_t;

    logic       CLK;
    logic       reset_n;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic [7:0] scan_code;
    logic       is_break;
    logic       is_extended;
    logic       code_valid;
    logic       frame_err;

    int  total = 0;
    int  bad   = 0;
    int  cv_seen  = 0;
    int  err_seen = 0;
    ev_t exp_q[$];
    bit  m_ext = 0;
    bit  m_brk = 0;

    ps2_scancode_rx #(
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (10000)
    ) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .PS2_CLK     (PS2_CLK),
        .PS2_DATA    (PS2_DATA),
        .scan_code   (scan_code),
        .is_break    (is_break),
        .is_extended (is_extended),
        .code_valid  (code_valid),
        .frame_err   (frame_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Frame-level model: decides what the receiver must report for a frame.
    task automatic model_frame(input logic [7:0] b, input logic p, input logic stop);
        ev_t e;
        e = '{is_err: 1'b0, code: b, brk: m_brk, ext: m_ext};
        if (((^b) ^ p) != 1'b1 || stop != 1'b1) begin
            e.is_err = 1'b1;
            exp_q.push_back(e);
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            exp_q.push_back(e);
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic ps2_bit(input logic v);
        PS2_DATA = v;
        wait_cyc(HALF);
        PS2_CLK = 1'b0;
        wait_cyc(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_bad, input logic stop);
        logic p;
        p = (~^b) ^ par_bad;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        model_frame(b, p, stop);
        ps2_bit(stop);
        PS2_DATA = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            wait_cyc(1);
            n++;
        end
        wait_cyc(10);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every strobe must match the next expected event; between
    // strobes the reported code and flags must not move.
    initial begin
        ev_t        e;
        logic [9:0] prev_o;
        logic [9:0] cur;
        logic       prev_cv;
        prev_o  = '0;
        prev_cv = 1'b0;
        forever begin
            @(negedge CLK);
            cur = {scan_code, is_break, is_extended};
            if (!reset_n) begin
                prev_o  = cur;
                prev_cv = 1'b0;
            end else begin
                if (code_valid || frame_err) begin
                    check("cv_err_exclusive", {31'd0, code_valid & frame_err}, 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", {30'd0, code_valid, frame_err}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                        if (!e.is_err) check("event_code", {22'd0, cur}, {22'd0, e.code, e.brk, e.ext});
                    end
                    if (code_valid) cv_seen++;
                    if (frame_err)  err_seen++;
                end
                if (code_valid) check("cv_one_cycle", {31'd0, prev_cv}, 0);
                else            check("hold_outputs", {22'd0, cur}, {22'd0, prev_o});
                prev_o  = cur;
                prev_cv = code_valid;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cv0;
        int err0;
        reset_n  = 1'b0;
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        wait_cyc(5);
        check("reset_outputs", {22'd0, scan_code, is_break, is_extended, code_valid, frame_err}, 0);
        reset_n = 1'b1;
        wait_cyc(10);

        // 1: plain make code
        cv0 = cv_seen;
        send_frame(8'h1D, 1'b0, 1'b1);
        wait_drain("t1_drain");
        check("t1_code", {24'd0, scan_code}, 32'h1D);
        check("t1_flags", {30'd0, is_break, is_extended}, 0);
        check("t1_one_cv", cv_seen - cv0, 1);

        // 2: break code
        cv0 = cv_seen;
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1D, 1'b0, 1'b1);
        wait_drain("t2_drain");
        check("t2_one_cv", cv_seen - cv0, 1);
        check("t2_out", {22'd0, scan_code, is_break, is_extended}, {22'd0, 8'h1D, 2'b10});

        // 3: extended break, then plain
        cv0 = cv_seen;
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        wait_drain("t3_drain_a");
        check("t3_one_cv", cv_seen - cv0, 1);
        check("t3_out", {22'd0, scan_code, is_break, is_extended}, {22'd0, 8'h75, 2'b11});
        send_frame(8'h75, 1'b0, 1'b1);
        wait_drain("t3_drain_b");
        check("t3_plain", {22'd0, scan_code, is_break, is_extended}, {22'd0, 8'h75, 2'b00});

        // 4: parity error, stop error, error clears a pending prefix
        cv0  = cv_seen;
        err0 = err_seen;
        send_frame(8'h1D, 1'b1, 1'b1);
        wait_drain("t4_drain_a");
        check("t4_err", err_seen - err0, 1);
        check("t4_no_cv", cv_seen - cv0, 0);
        check("t4_keep", {24'd0, scan_code}, 32'h75);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h6B, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b1);
        wait_drain("t4_drain_b");
        check("t4_after_err", {22'd0, scan_code, is_break, is_extended}, {22'd0, 8'h6B, 2'b00});

        // 5: timeout mid-frame, pending break dropped
        send_frame(8'hF0, 1'b0, 1'b1);
        err0 = err_seen;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        exp_q.push_back('{is_err: 1'b1, code: 8'h00, brk: 1'b0, ext: 1'b0});
        m_ext = 0;
        m_brk = 0;
        wait_cyc(10001);
        wait_drain("t5_drain_a");
        check("t5_err", err_seen - err0, 1);
        check("t5_idle", {30'd0, dut.r_state}, {30'd0, IDLE});
        send_frame(8'h29, 1'b0, 1'b1);
        wait_drain("t5_drain_b");
        check("t5_next", {22'd0, scan_code, is_break, is_extended}, {22'd0, 8'h29, 2'b00});

        // 6a: short glitch on PS2_CLK with data low must not start a frame
        cv0  = cv_seen;
        err0 = err_seen;
        PS2_DATA = 1'b0;
        PS2_CLK  = 1'b0;
        wait_cyc(2);
        PS2_CLK  = 1'b1;
        wait_cyc(30);
        PS2_DATA = 1'b1;
        check("t6_glitch_idle", {30'd0, dut.r_state}, {30'd0, IDLE});
        check("t6_glitch_quiet", (cv_seen - cv0) + (err_seen - err0), 0);
        send_frame(8'h1C, 1'b0, 1'b1);
        wait_drain("t6_drain_a");
        check("t6_after_glitch", {24'd0, scan_code}, 32'h1C);

        // 6b: reset mid-frame loses partial frame and pending prefix
        send_frame(8'hE0, 1'b0, 1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        reset_n = 1'b0;
        #1;
        check("t6_reset_outputs", {22'd0, scan_code, is_break, is_extended, code_valid, frame_err}, 0);
        m_ext = 0;
        m_brk = 0;
        exp_q.delete();
        wait_cyc(5);
        PS2_DATA = 1'b1;
        reset_n  = 1'b1;
        wait_cyc(10);
        send_frame(8'h1D, 1'b0, 1'b1);
        wait_drain("t6_drain_b");
        check("t6_after_reset", {22'd0, scan_code, is_break, is_extended}, {22'd0, 8'h1D, 2'b00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
